operand_regs: RTL and testbench
===============================

OPERAND_REGS -- requirements
Module: operand_regs

Interface
REQ-001 The module SHALL have one parameter: WIDTH, default 8, data width of bus, registers and adder operands.
REQ-002 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port clr_n, input, 1: reset, synchronous and active-low, sampled on the rising edge of clk.
REQ-004 Port bus, inout, WIDTH: shared system bus; the module drives it only per REQ-012.
REQ-005 Port la_n, input, 1: active-low load of accumulator A from bus.
REQ-006 Port lb_n, input, 1: active-low load of register B from bus.
REQ-007 Port ea, input, 1: active-high enable of A onto bus.
REQ-008 Port sub, input, 1: current adder mode, used for the overflow flag; 1 means subtract.
REQ-009 Port sum, input, WIDTH: adder result consumed from the downstream adder/subtractor.
REQ-010 Port cout, input, 1: adder carry-out.
REQ-011 Ports a_q and b_q, output, WIDTH each: registered A and B, wired to the adder operand inputs. Port flg_ld, input, 1: flag capture strobe. Port flags, output, 4: {V,S,Z,C}. Port conflict, output, 1: registered illegal-command indicator.

Function
REQ-012 bus SHALL equal a_q while ea=1, and high-impedance on every bit while ea=0.
REQ-013 When la_n=0, ea=0 and clr_n=1, A SHALL take the bus value at the edge; the load latency is one cycle.
REQ-014 When lb_n=0 and clr_n=1, B SHALL take the bus value at the edge; B is never driven onto bus.
REQ-015 When la_n=0 and lb_n=0 in the same cycle, both registers SHALL load the same bus value.
REQ-016 When la_n=0 and ea=1 in the same cycle, A SHALL hold its value and conflict SHALL be 1 for exactly the following cycle.
REQ-017 In every other cycle, conflict SHALL be 0 the cycle after; conflict is not sticky.
REQ-018 When flg_ld=1, the flags SHALL capture on the edge: C=cout; Z=1 iff sum is all zeros; S=sum[WIDTH-1].
REQ-019 V SHALL be computed as follows: for sub=0, V=1 iff a_q[MSB]=b_q[MSB] and sum[MSB] differs from them; for sub=1, V=1 iff a_q[MSB] differs from b_q[MSB] and sum[MSB] differs from a_q[MSB].
REQ-020 When flg_ld=0, the flags SHALL hold.
REQ-021 Flags SHALL be sampled from the pre-edge a_q, b_q and sum; a simultaneous A or B load does not affect that capture.
REQ-022 Register values SHALL wrap modulo 2^WIDTH; no saturation is applied.

Reset
REQ-023 With clr_n=0 at a rising edge, a_q, b_q, flags and conflict SHALL become 0, overriding all loads and flg_ld in that cycle.
REQ-024 bus SHALL still follow ea during reset; after clr_n deasserts, a_q drives 0 when ea=1.
REQ-025 A reset asserted mid-sequence SHALL discard any load in that cycle; the next cycle behaves as if from power-up.

Configuration
REQ-026 Macro OPERAND_REGS_FLAGS_EN SHALL control the flags logic.
REQ-027 When OPERAND_REGS_FLAGS_EN is defined, flags SHALL behave per REQ-018 to REQ-021 and REQ-023.
REQ-028 When OPERAND_REGS_FLAGS_EN is undefined, flags SHALL be constant 0, flg_ld, sum, cout and sub SHALL be ignored, and no flag registers SHALL be inferred.

Verification
REQ-029 Reset check: clr_n=0 for 2 cycles with la_n=0 and bus=8'hAA -> a_q=0, b_q=0, flags=0, conflict=0.
REQ-030 Load check: bus=8'h05 with la_n=0, then bus=8'h03 with lb_n=0, then ea=1 -> a_q=05, b_q=03, bus reads 05; with ea=0, bus=Z.
REQ-031 Flag check, add: a_q=7F, b_q=01, sub=0, sum=80, cout=0, flg_ld=1 -> flags {V,S,Z,C}=1100.
REQ-032 Flag check, subtract: a_q=05, b_q=05, sub=1, sum=00, cout=1, flg_ld=1 -> flags=0011; a following cycle with flg_ld=0 and sum=FF -> flags stay 0011.
REQ-033 Conflict check: a_q=12, la_n=0, ea=1 -> a_q stays 12, conflict=1 for one cycle, then 0.
REQ-034 Build check: compile without OPERAND_REGS_FLAGS_EN and repeat REQ-031 -> flags=0000.

Source files
------------

// File: rtl/operand_regs.sv
// ---------------------------------------------------------------------------
// operand_regs
//
// Accumulator A and operand register B sitting on a shared tristate bus,
// feeding a downstream adder/subtractor, plus an optional {V,S,Z,C} status
// flag register captured from the adder result.
//
// Build option:
//   OPERAND_REGS_FLAGS_EN - when defined, the flag register is built and
//                           captures on flg_ld. When undefined, flags reads
//                           constant 0, and sum/cout/sub/flg_ld are ignored.
//
// Ports:
//   clk      in   rising-edge clock for all state
//   clr_n    in   synchronous active-low clear of A, B, flags and conflict
//   bus      io   shared bus; driven with a_q only while ea=1
//   la_n     in   active-low load of A from bus (blocked while ea=1)
//   lb_n     in   active-low load of B from bus
//   ea       in   active-high enable of A onto bus
//   sub      in   adder mode (1 = subtract), selects the overflow rule
//   sum      in   adder result
//   cout     in   adder carry-out
//   flg_ld   in   flag capture strobe
//   a_q      out  registered A (adder operand)
//   b_q      out  registered B (adder operand)
//   flags    out  {V,S,Z,C}
//   conflict out  1 for the cycle after la_n=0 coincided with ea=1
// ---------------------------------------------------------------------------
module operand_regs #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    inout  wire  [WIDTH-1:0] bus,
    input  logic             la_n,
    input  logic             lb_n,
    input  logic             ea,
    input  logic             sub,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    input  logic             flg_ld,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q,
    output logic [3:0]       flags,
    output logic             conflict
);

    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic             conflict_d;

    assign bus = ea ? a_q : {WIDTH{1'bz}};

    // A cannot load from a bus it is itself driving; that request is
    // flagged as a conflict instead of being honoured.
    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        conflict_d = 1'b0;
        if (!la_n && !ea) begin
            a_d = bus;
        end
        if (!lb_n) begin
            b_d = bus;
        end
        if (!la_n && ea) begin
            conflict_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            a_q      <= '0;
            b_q      <= '0;
            conflict <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            conflict <= conflict_d;
        end
    end

`ifdef OPERAND_REGS_FLAGS_EN
    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       v_flag;

    // Overflow: result sign differs from A, and the operand signs are equal
    // for add / different for subtract (B is effectively negated).
    always_comb begin
        v_flag  = (sum[WIDTH-1] ^ a_q[WIDTH-1])
                & ~(a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ sub);
        flags_d = flags_q;
        if (flg_ld) begin
            flags_d = {v_flag, sum[WIDTH-1], (sum == '0), cout};
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;
`else
    logic unused_flag_inputs;

    assign unused_flag_inputs = ^{sum, cout, sub, flg_ld};
    assign flags              = '0;
`endif

endmodule

// File: tb/tb_operand_regs.sv
module tb_operand_regs;

`ifdef OPERAND_REGS_FLAGS_EN
    localparam bit FEN = 1'b1;
`else
    localparam bit FEN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clr_n, la_n, lb_n, ea, sub, cout, flg_ld;
    logic [7:0] sum;
    logic [7:0] a_q, b_q;
    logic [3:0] flags;
    logic       conflict;
    logic       bus_en;
    logic [7:0] bus_drv;
    wire  [7:0] bus;

    assign bus = bus_en ? bus_drv : 8'bzzzz_zzzz;

    operand_regs #(.WIDTH(8)) dut (
        .clk(clk), .clr_n(clr_n), .bus(bus), .la_n(la_n), .lb_n(lb_n),
        .ea(ea), .sub(sub), .sum(sum), .cout(cout), .flg_ld(flg_ld),
        .a_q(a_q), .b_q(b_q), .flags(flags), .conflict(conflict)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       clr_n, la_n, lb_n, ea, drv;
        logic [7:0] busv;
        logic       flg_ld, sub;
        logic [7:0] sum;
        logic       cout;
        logic [7:0] exp_a, exp_b;
        logic [3:0] exp_f;
        logic       exp_c;
    } vec_t;

    typedef struct {
        logic [7:0] a, b;
        logic [3:0] f;
        logic       c;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(logic c, logic la, logic lb, logic e, logic d,
                                logic [7:0] bv, logic fl, logic sb_, logic [7:0] s,
                                logic co, logic [7:0] xa, logic [7:0] xb,
                                logic [3:0] xf, logic xc);
        vec_t v;
        v.clr_n = c; v.la_n = la; v.lb_n = lb; v.ea = e; v.drv = d; v.busv = bv;
        v.flg_ld = fl; v.sub = sb_; v.sum = s; v.cout = co;
        v.exp_a = xa; v.exp_b = xb; v.exp_f = FEN ? xf : 4'b0000; v.exp_c = xc;
        return v;
    endfunction

    task automatic chk8(string name, logic [7:0] act, logic [7:0] req);
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic chk_out(string name);
        exp_t e;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        chk8({name, " a_q"}, a_q, e.a);
        chk8({name, " b_q"}, b_q, e.b);
        chk8({name, " flags"}, {4'b0, flags}, {4'b0, e.f});
        chk8({name, " conflict"}, {7'b0, conflict}, {7'b0, e.c});
    endtask

    task automatic idle();
        clr_n = 1'b1; la_n = 1'b1; lb_n = 1'b1; ea = 1'b0; bus_en = 1'b0;
        bus_drv = 8'h00; flg_ld = 1'b0; sub = 1'b0; sum = 8'h00; cout = 1'b0;
    endtask

    initial begin
        logic [7:0] prev_a;
        exp_t       e;
        idle();
        //          clr la lb ea drv bus  fl sb sum  co   a     b     f        c
        vecs.push_back(mk(0, 0, 1, 0, 1, 8'hAA, 0, 0, 8'h00, 0, 8'h00, 8'h00, 4'b0000, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 8'hAA, 0, 0, 8'h00, 0, 8'h00, 8'h00, 4'b0000, 0));
        vecs.push_back(mk(1, 0, 1, 0, 1, 8'h05, 0, 0, 8'h00, 0, 8'h05, 8'h00, 4'b0000, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 8'h03, 0, 0, 8'h00, 0, 8'h05, 8'h03, 4'b0000, 0));
        vecs.push_back(mk(1, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 8'h05, 8'h03, 4'b0000, 0));
        vecs.push_back(mk(1, 0, 1, 0, 1, 8'h7F, 0, 0, 8'h00, 0, 8'h7F, 8'h03, 4'b0000, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 8'h01, 0, 0, 8'h00, 0, 8'h7F, 8'h01, 4'b0000, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 8'h00, 1, 1, 8'h00, 1, 8'h7F, 8'h01, 4'b0011, 0));
        // flags use pre-edge B=01 (V=1) although B loads FF in the same cycle
        vecs.push_back(mk(1, 1, 0, 0, 1, 8'hFF, 1, 0, 8'h80, 0, 8'h7F, 8'hFF, 4'b1100, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 8'h05, 0, 0, 8'h00, 0, 8'h05, 8'h05, 4'b1100, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 8'h00, 1, 1, 8'h00, 1, 8'h05, 8'h05, 4'b0011, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 8'h00, 0, 0, 8'hFF, 0, 8'h05, 8'h05, 4'b0011, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 8'h80, 0, 0, 8'h00, 0, 8'h05, 8'h80, 4'b0011, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 8'h00, 1, 1, 8'h85, 1, 8'h05, 8'h80, 4'b1101, 0));
        vecs.push_back(mk(1, 0, 1, 0, 1, 8'h12, 0, 0, 8'h00, 0, 8'h12, 8'h80, 4'b1101, 0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 8'h12, 8'h80, 4'b1101, 1));
        vecs.push_back(mk(1, 1, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h12, 8'h80, 4'b1101, 0));
        vecs.push_back(mk(1, 1, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 8'h12, 8'h12, 4'b1101, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 8'hFF, 0, 0, 8'h00, 0, 8'hFF, 8'hFF, 4'b1101, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 8'h66, 1, 0, 8'h00, 1, 8'h00, 8'h00, 4'b0000, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 8'h00, 4'b0000, 0));
        vecs.push_back(mk(1, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 8'h00, 4'b0000, 0));
        vecs.push_back(mk(1, 0, 1, 0, 1, 8'h01, 0, 0, 8'h00, 0, 8'h01, 8'h00, 4'b0000, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 8'h00, 4'b0000, 0));

        prev_a = 8'h00;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            clr_n = vecs[i].clr_n; la_n = vecs[i].la_n; lb_n = vecs[i].lb_n;
            ea = vecs[i].ea; bus_en = vecs[i].drv && !vecs[i].ea;
            bus_drv = vecs[i].busv; flg_ld = vecs[i].flg_ld; sub = vecs[i].sub;
            sum = vecs[i].sum; cout = vecs[i].cout;
            e.a = vecs[i].exp_a; e.b = vecs[i].exp_b;
            e.f = vecs[i].exp_f; e.c = vecs[i].exp_c;
            sb.push_back(e);
            #1;
            if (vecs[i].ea && i > 0) chk8($sformatf("v%0d bus", i), bus, prev_a);
            @(posedge clk);
            #1;
            n_vec++;
            chk_out($sformatf("v%0d", i));
            prev_a = vecs[i].exp_a;
        end

        // Released bus: load A=05, then ea=0 with nothing else driving
        @(negedge clk);
        idle();
        la_n = 1'b0; bus_en = 1'b1; bus_drv = 8'h05;
        @(posedge clk);
        #1;
        @(negedge clk);
        idle();
        #1;
        n_vec++;
        if (!((bus === 8'hzz) || (bus === 8'h00))) begin
            n_err++;
            $display("FAIL bus_release: got %h expected zz", bus);
        end
        bus_en = 1'b1; bus_drv = 8'h3C;
        #1;
        n_vec++;
        chk8("bus_tb_drive", bus, 8'h3C);
        chk8("a_hold", a_q, 8'h05);

        // Add-overflow capture on a disabled build must leave flags at 0
        @(negedge clk);
        idle();
        la_n = 1'b0; bus_en = 1'b1; bus_drv = 8'h7F;
        @(negedge clk);
        idle();
        lb_n = 1'b0; bus_en = 1'b1; bus_drv = 8'h01;
        @(negedge clk);
        idle();
        flg_ld = 1'b1; sub = 1'b0; sum = 8'h80; cout = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        chk8("flags_add", {4'b0, flags}, FEN ? 8'h0C : 8'h00);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
